// File: rtl/can_pkg.sv
// Shared constants, state encoding and the CRC-15 step function for the CAN RX checker.
package can_pkg;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int ID_A_LEN  = 11;
  localparam int ID_B_LEN  = 18;
  localparam int DLC_LEN   = 4;
  localparam int CRC_LEN   = 15;
  localparam int STUFF_RUN = 5;

  typedef enum logic [2:0] {
    IDLE,
    ARB_A,
    CTRL,
    ARB_B,
    DLC_F,
    DATA,
    CRC_F,
    CRC_DEL
  } rx_state_t;

  // One serial CRC-15 step: feedback is the incoming bit xor the register MSB.
  function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15_step.sv
// Serial CRC-15 LFSR; clr restarts from zero and may coincide with the first fed bit.
module can_crc15_step
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        bit_in,
  output logic [14:0] crc
);

  // Advance the LFSR by one bit, starting from zero when clr accompanies the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc15_next(clr ? 15'h0000 : crc, bit_in);
    end else if (clr) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/can_rx_frame_check.sv
// CAN 2.0A/B receive frame checker: destuffs sampled bits, tracks fields SOF..CRC
// delimiter, recomputes CRC-15 and flags CRC, stuff and delimiter-form errors.
module can_rx_frame_check
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_val,
  input  logic        bit_strb,
  output logic        busy,
  output logic [28:0] frame_id,
  output logic        ide,
  output logic        rtr,
  output logic [3:0]  dlc,
  output logic [7:0]  byte_out,
  output logic        byte_vld,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err
);

  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_BITS);

  rx_state_t   state, state_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic [4:0]  fld_cnt, fld_cnt_n;
  logic [6:0]  data_cnt, data_cnt_n;
  logic [2:0]  run_cnt, run_cnt_n;
  logic        run_val, run_val_n;
  logic [7:0]  byte_sh, byte_sh_n;
  logic [28:0] frame_id_n;
  logic        ide_n, rtr_n, busy_n;
  logic [3:0]  dlc_n;
  logic [7:0]  byte_out_n;
  logic        byte_vld_n, crc_ok_n, crc_err_n, stuff_err_n, form_err_n;
  logic        crc_en, crc_clr, abort;
  logic [14:0] crc;
  logic [6:0]  data_len;

  can_crc15_step u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (crc_en),
    .clr    (crc_clr),
    .bit_in (bit_val),
    .crc    (crc)
  );

  // Data field length in bits; DLC values above 8 still carry 8 bytes.
  assign data_len = dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000};

  // Next-state logic: idle detection, destuffing, field sequencing and result flags.
  always_comb begin
    state_n     = state;
    idle_cnt_n  = idle_cnt;
    fld_cnt_n   = fld_cnt;
    data_cnt_n  = data_cnt;
    run_cnt_n   = run_cnt;
    run_val_n   = run_val;
    byte_sh_n   = byte_sh;
    frame_id_n  = frame_id;
    ide_n       = ide;
    rtr_n       = rtr;
    dlc_n       = dlc;
    byte_out_n  = byte_out;
    busy_n      = busy;
    byte_vld_n  = 1'b0;
    crc_ok_n    = 1'b0;
    crc_err_n   = 1'b0;
    stuff_err_n = 1'b0;
    form_err_n  = 1'b0;
    crc_en      = 1'b0;
    crc_clr     = 1'b0;
    abort       = 1'b0;
    if (bit_strb) begin
      if (state == IDLE) begin
        if (bit_val) begin
          if (idle_cnt != IDLE_MAX) idle_cnt_n = idle_cnt + 1'b1;
        end else if (idle_cnt == IDLE_MAX) begin
          // SOF: restart CRC with the SOF bit already fed, run of one dominant bit
          state_n    = ARB_A;
          busy_n     = 1'b1;
          crc_clr    = 1'b1;
          crc_en     = 1'b1;
          fld_cnt_n  = '0;
          run_cnt_n  = 3'd1;
          run_val_n  = 1'b0;
          frame_id_n = '0;
          ide_n      = 1'b0;
          rtr_n      = 1'b0;
          dlc_n      = '0;
        end else begin
          idle_cnt_n = '0;
        end
      end else if (run_cnt == 3'(STUFF_RUN)) begin
        // Stuff bit slot: must differ from the run, never reaches CRC or fields
        if (bit_val == run_val) begin
          stuff_err_n = 1'b1;
          abort       = 1'b1;
        end else begin
          run_val_n = bit_val;
          run_cnt_n = 3'd1;
        end
      end else if (state == CRC_DEL) begin
        if (bit_val) begin
          crc_ok_n  = (crc == 15'h0000);
          crc_err_n = (crc != 15'h0000);
        end else begin
          form_err_n = 1'b1;
        end
        abort = 1'b1;
      end else begin
        if (bit_val == run_val) begin
          run_cnt_n = run_cnt + 3'd1;
        end else begin
          run_val_n = bit_val;
          run_cnt_n = 3'd1;
        end
        crc_en    = 1'b1;
        fld_cnt_n = fld_cnt + 5'd1;
        case (state)
          ARB_A: begin
            frame_id_n = {frame_id[27:0], bit_val};
            if (fld_cnt == 5'(ID_A_LEN - 1)) begin
              state_n   = CTRL;
              fld_cnt_n = '0;
            end
          end
          CTRL: begin
            if (fld_cnt == 5'd0) begin
              rtr_n = bit_val;
            end else if (fld_cnt == 5'd1) begin
              ide_n = bit_val;
              if (bit_val) begin
                state_n   = ARB_B;
                fld_cnt_n = '0;
              end
            end else begin
              state_n   = DLC_F;
              fld_cnt_n = '0;
            end
          end
          ARB_B: begin
            if (fld_cnt < 5'(ID_B_LEN)) begin
              frame_id_n = {frame_id[27:0], bit_val};
            end else if (fld_cnt == 5'(ID_B_LEN)) begin
              rtr_n = bit_val;
            end else if (fld_cnt == 5'(ID_B_LEN + 2)) begin
              state_n   = DLC_F;
              fld_cnt_n = '0;
            end
          end
          DLC_F: begin
            dlc_n = {dlc[2:0], bit_val};
            if (fld_cnt == 5'(DLC_LEN - 1)) begin
              fld_cnt_n  = '0;
              data_cnt_n = '0;
              state_n    = (rtr || dlc_n == 4'd0) ? CRC_F : DATA;
            end
          end
          DATA: begin
            byte_sh_n  = {byte_sh[6:0], bit_val};
            data_cnt_n = data_cnt + 7'd1;
            fld_cnt_n  = '0;
            if (data_cnt[2:0] == 3'd7) begin
              byte_out_n = byte_sh_n;
              byte_vld_n = 1'b1;
            end
            if (data_cnt == data_len - 7'd1) state_n = CRC_F;
          end
          CRC_F: begin
            if (fld_cnt == 5'(CRC_LEN - 1)) begin
              state_n   = CRC_DEL;
              fld_cnt_n = '0;
            end
          end
          default: ;
        endcase
      end
      if (abort) begin
        state_n    = IDLE;
        idle_cnt_n = '0;
        busy_n     = 1'b0;
        run_cnt_n  = '0;
      end
    end
  end

  // State and output registers; reset aborts any frame in progress without a flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      fld_cnt   <= '0;
      data_cnt  <= '0;
      run_cnt   <= '0;
      run_val   <= 1'b0;
      byte_sh   <= '0;
      frame_id  <= '0;
      ide       <= 1'b0;
      rtr       <= 1'b0;
      dlc       <= '0;
      byte_out  <= '0;
      busy      <= 1'b0;
      byte_vld  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      stuff_err <= 1'b0;
      form_err  <= 1'b0;
    end else begin
      state     <= state_n;
      idle_cnt  <= idle_cnt_n;
      fld_cnt   <= fld_cnt_n;
      data_cnt  <= data_cnt_n;
      run_cnt   <= run_cnt_n;
      run_val   <= run_val_n;
      byte_sh   <= byte_sh_n;
      frame_id  <= frame_id_n;
      ide       <= ide_n;
      rtr       <= rtr_n;
      dlc       <= dlc_n;
      byte_out  <= byte_out_n;
      busy      <= busy_n;
      byte_vld  <= byte_vld_n;
      crc_ok    <= crc_ok_n;
      crc_err   <= crc_err_n;
      stuff_err <= stuff_err_n;
      form_err  <= form_err_n;
    end
  end

endmodule
